// File: rtl/dft_axil_pkg.sv
// -----------------------------------------------------------------------------
// dft_axil_pkg
// Shared definitions for the DFT AXI4-Lite register front end:
//   - word indices of the fixed registers at the bottom of the map
//   - AXI response codes
//   - write / read FSM state encodings
//   - strb_merge(): byte-lane merge used by strobed register writes
// -----------------------------------------------------------------------------
package dft_axil_pkg;

  localparam int ID_IDX       = 0;
  localparam int IRQ_STAT_IDX = 1;
  localparam int IRQ_EN_IDX   = 2;
  localparam int CTRL_BASE    = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_HAVE_AW = 2'd1,
    WR_HAVE_W  = 2'd2,
    WR_RESP    = 2'd3
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

  // Take byte b from new_val where strb[b] is set, otherwise keep old_val.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dft_axil_irq.sv
// -----------------------------------------------------------------------------
// dft_axil_irq
// Interrupt status (write-1-to-clear) and enable registers plus the registered
// level interrupt output.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   irq_src_i         one-cycle event pulses, one per source
//   stat_wr_i         committed write to IRQ_STATUS this cycle (W1C)
//   en_wr_i           committed write to IRQ_ENABLE this cycle
//   wdata_i, wstrb_i  write data and effective byte strobes
//   status_o          IRQ_STATUS, zero-extended to 32 bits
//   enable_o          IRQ_ENABLE, zero-extended to 32 bits
//   interrupt_o       registered |(status & enable)
// -----------------------------------------------------------------------------
module dft_axil_irq
  import dft_axil_pkg::*;
#(
  parameter int IRQ_WIDTH = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IRQ_WIDTH-1:0] irq_src_i,
  input  logic                 stat_wr_i,
  input  logic                 en_wr_i,
  input  logic [31:0]          wdata_i,
  input  logic [3:0]           wstrb_i,
  output logic [31:0]          status_o,
  output logic [31:0]          enable_o,
  output logic                 interrupt_o
);

  logic [IRQ_WIDTH-1:0] status_q, status_d;
  logic [IRQ_WIDTH-1:0] enable_q, enable_d;
  logic                 interrupt_q;
  logic [31:0]          clr_mask_s;
  logic [31:0]          en_merged_s;
  logic                 unused_s;

  // Next-state for status/enable: a new event is OR-ed in after the clear,
  // so a set in the same cycle as a W1C of that bit wins.
  always_comb begin
    clr_mask_s  = 32'h0000_0000;
    en_merged_s = strb_merge(32'(enable_q), wdata_i, wstrb_i);
    if (stat_wr_i) begin
      clr_mask_s = wdata_i & strb_merge(32'h0000_0000, 32'hFFFF_FFFF, wstrb_i);
    end else begin
      clr_mask_s = 32'h0000_0000;
    end
    status_d = (status_q & ~clr_mask_s[IRQ_WIDTH-1:0]) | irq_src_i;
    if (en_wr_i) begin
      enable_d = en_merged_s[IRQ_WIDTH-1:0];
    end else begin
      enable_d = enable_q;
    end
  end

  // Status, enable and interrupt registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      status_q    <= '0;
      enable_q    <= '0;
      interrupt_q <= 1'b0;
    end else begin
      status_q    <= status_d;
      enable_q    <= enable_d;
      interrupt_q <= |(status_q & enable_q);
    end
  end

  assign status_o    = 32'(status_q);
  assign enable_o    = 32'(enable_q);
  assign interrupt_o = interrupt_q;

  // Bits above IRQ_WIDTH of the 32-bit helpers are intentionally dropped.
  assign unused_s = ^{clr_mask_s, en_merged_s};

endmodule

// File: rtl/dft_axil_regs.sv
// -----------------------------------------------------------------------------
// dft_axil_regs
// Parametrised AXI4-Lite slave register file for the DFT core.
// Word map: 0 ID (RO), 1 IRQ_STATUS (W1C), 2 IRQ_ENABLE (RW),
//           3.. NUM_CTRL control regs (RW), then NUM_STAT status regs (RO).
//           Anything beyond is unmapped and answered with SLVERR.
// Ports:
//   AXI_S_ACLK / AXI_S_ARESET   clock, asynchronous active-high reset
//   AXI_S_AW* / W* / B*         write address, data, response channels
//   AXI_S_AR* / R*              read address and data channels
//   CTRL_OUT                    control registers, reg k at [32k+31:32k]
//   STAT_IN                     status inputs, sampled at the AR handshake
//   IRQ_SRC                     interrupt event pulses
//   INTERRUPT                   registered level interrupt
// Build option: define DFT_AXIL_WSTRB_EN to honour WSTRB on IRQ_STATUS,
// IRQ_ENABLE and CTRL writes; without it every write is full-word.
// -----------------------------------------------------------------------------
module dft_axil_regs
  import dft_axil_pkg::*;
#(
  parameter int          ADDR_WIDTH = 24,
  parameter int          NUM_CTRL   = 4,
  parameter int          NUM_STAT   = 4,
  parameter int          IRQ_WIDTH  = 1,
  parameter logic [31:0] BLOCK_ID   = 32'hDF70_0002
) (
  input  logic                     AXI_S_ACLK,
  input  logic                     AXI_S_ARESET,
  input  logic                     AXI_S_AWVALID,
  output logic                     AXI_S_AWREADY,
  input  logic [ADDR_WIDTH-1:0]    AXI_S_AWADDR,
  input  logic [2:0]               AXI_S_AWPROT,
  input  logic                     AXI_S_WVALID,
  output logic                     AXI_S_WREADY,
  input  logic [31:0]              AXI_S_WDATA,
  input  logic [3:0]               AXI_S_WSTRB,
  output logic                     AXI_S_BVALID,
  input  logic                     AXI_S_BREADY,
  output logic [1:0]               AXI_S_BRESP,
  input  logic                     AXI_S_ARVALID,
  output logic                     AXI_S_ARREADY,
  input  logic [ADDR_WIDTH-1:0]    AXI_S_ARADDR,
  input  logic [2:0]               AXI_S_ARPROT,
  output logic                     AXI_S_RVALID,
  input  logic                     AXI_S_RREADY,
  output logic [31:0]              AXI_S_RDATA,
  output logic [1:0]               AXI_S_RRESP,
  output logic [NUM_CTRL*32-1:0]   CTRL_OUT,
  input  logic [NUM_STAT*32-1:0]   STAT_IN,
  input  logic [IRQ_WIDTH-1:0]     IRQ_SRC,
  output logic                     INTERRUPT
);

  localparam int IDXW      = ADDR_WIDTH - 2;
  localparam int STAT_BASE = CTRL_BASE + NUM_CTRL;
  localparam int MAP_END   = STAT_BASE + NUM_STAT;

  // ---------------- write path ----------------
  wr_state_e             wr_state_q, wr_state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  aw_hs_s, w_hs_s, b_hs_s, commit_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [IDXW-1:0]       wr_idx_s;
  logic [31:0]           wr_data_s;
  logic [3:0]            wr_strb_s;
  logic                  wr_mapped_s;
  logic                  stat_wr_s, en_wr_s;
  logic [31:0]           ctrl_q [NUM_CTRL];

  // ---------------- read path ----------------
  rd_state_e             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  ar_hs_s, r_hs_s;
  logic [IDXW-1:0]       rd_idx_s;
  logic [31:0]           rd_word_s;
  logic                  rd_mapped_s;

  logic [31:0]           irq_status_s, irq_enable_s;
  logic                  interrupt_s;
  logic                  unused_s;

  assign aw_hs_s = AXI_S_AWVALID & awready_q;
  assign w_hs_s  = AXI_S_WVALID  & wready_q;
  assign b_hs_s  = bvalid_q      & AXI_S_BREADY;
  assign ar_hs_s = AXI_S_ARVALID & arready_q;
  assign r_hs_s  = rvalid_q      & AXI_S_RREADY;

  // Commit operands: take the live channel when it handshakes this cycle,
  // otherwise the copy captured by an earlier handshake.
  always_comb begin
    if (aw_hs_s) begin
      wr_addr_s = AXI_S_AWADDR;
    end else begin
      wr_addr_s = awaddr_q;
    end
    if (w_hs_s) begin
      wr_data_s = AXI_S_WDATA;
    end else begin
      wr_data_s = wdata_q;
    end
`ifdef DFT_AXIL_WSTRB_EN
    if (w_hs_s) begin
      wr_strb_s = AXI_S_WSTRB;
    end else begin
      wr_strb_s = wstrb_q;
    end
`else
    wr_strb_s = 4'hF;
`endif
    wr_idx_s    = wr_addr_s[ADDR_WIDTH-1:2];
    wr_mapped_s = (wr_idx_s < IDXW'(MAP_END));
    stat_wr_s   = commit_s & (wr_idx_s == IDXW'(IRQ_STAT_IDX));
    en_wr_s     = commit_s & (wr_idx_s == IDXW'(IRQ_EN_IDX));
  end

  // Write FSM next state. The commit happens on the edge at which the second
  // of AW/W is accepted; READYs are registered and only re-open one cycle
  // after the FSM is back in IDLE, giving one write per three cycles.
  always_comb begin
    wr_state_d = wr_state_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    commit_s   = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          commit_s   = 1'b1;
          wr_state_d = WR_RESP;
        end else if (aw_hs_s) begin
          wr_state_d = WR_HAVE_AW;
        end else if (w_hs_s) begin
          wr_state_d = WR_HAVE_W;
        end else begin
          wr_state_d = WR_IDLE;
        end
      end
      WR_HAVE_AW: begin
        if (w_hs_s) begin
          commit_s   = 1'b1;
          wr_state_d = WR_RESP;
        end else begin
          wr_state_d = WR_HAVE_AW;
        end
      end
      WR_HAVE_W: begin
        if (aw_hs_s) begin
          commit_s   = 1'b1;
          wr_state_d = WR_RESP;
        end else begin
          wr_state_d = WR_HAVE_W;
        end
      end
      WR_RESP: begin
        if (b_hs_s) begin
          wr_state_d = WR_IDLE;
        end else begin
          wr_state_d = WR_RESP;
        end
      end
      default: begin
        wr_state_d = WR_IDLE;
      end
    endcase

    if (aw_hs_s) begin
      awaddr_d = AXI_S_AWADDR;
    end else begin
      awaddr_d = awaddr_q;
    end
    if (w_hs_s) begin
      wdata_d = AXI_S_WDATA;
      wstrb_d = AXI_S_WSTRB;
    end else begin
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
    end

    if (commit_s) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_mapped_s ? RESP_OKAY : RESP_SLVERR;
    end else if (b_hs_s) begin
      bvalid_d = 1'b0;
      bresp_d  = RESP_OKAY;
    end else begin
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
    end

    awready_d = (wr_state_q != WR_RESP) &&
                ((wr_state_d == WR_IDLE) || (wr_state_d == WR_HAVE_W));
    wready_d  = (wr_state_q != WR_RESP) &&
                ((wr_state_d == WR_IDLE) || (wr_state_d == WR_HAVE_AW));
  end

  // Write FSM and write-channel registers.
  always_ff @(posedge AXI_S_ACLK or posedge AXI_S_ARESET) begin
    if (AXI_S_ARESET) begin
      wr_state_q <= WR_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      awaddr_q   <= '0;
      wdata_q    <= 32'h0000_0000;
      wstrb_q    <= 4'h0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  // Control registers, updated on the commit edge.
  always_ff @(posedge AXI_S_ACLK or posedge AXI_S_ARESET) begin
    if (AXI_S_ARESET) begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        ctrl_q[k] <= 32'h0000_0000;
      end
    end else begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (commit_s && (wr_idx_s == IDXW'(CTRL_BASE + k))) begin
          ctrl_q[k] <= strb_merge(ctrl_q[k], wr_data_s, wr_strb_s);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
    assign CTRL_OUT[32*g +: 32] = ctrl_q[g];
  end

  dft_axil_irq #(
    .IRQ_WIDTH (IRQ_WIDTH)
  ) u_irq (
    .clk_i       (AXI_S_ACLK),
    .rst_i       (AXI_S_ARESET),
    .irq_src_i   (IRQ_SRC),
    .stat_wr_i   (stat_wr_s),
    .en_wr_i     (en_wr_s),
    .wdata_i     (wr_data_s),
    .wstrb_i     (wr_strb_s),
    .status_o    (irq_status_s),
    .enable_o    (irq_enable_s),
    .interrupt_o (interrupt_s)
  );

  assign INTERRUPT = interrupt_s;

  // Read mux: word indices are disjoint, so every source is OR-ed in under
  // its own match; unmapped words fall through as zero.
  always_comb begin
    rd_idx_s    = AXI_S_ARADDR[ADDR_WIDTH-1:2];
    rd_mapped_s = (rd_idx_s < IDXW'(MAP_END));
    rd_word_s   = 32'h0000_0000;
    rd_word_s   = rd_word_s | ((rd_idx_s == IDXW'(ID_IDX))       ? BLOCK_ID     : 32'h0000_0000);
    rd_word_s   = rd_word_s | ((rd_idx_s == IDXW'(IRQ_STAT_IDX)) ? irq_status_s : 32'h0000_0000);
    rd_word_s   = rd_word_s | ((rd_idx_s == IDXW'(IRQ_EN_IDX))   ? irq_enable_s : 32'h0000_0000);
    for (int k = 0; k < NUM_CTRL; k++) begin
      rd_word_s = rd_word_s | ((rd_idx_s == IDXW'(CTRL_BASE + k)) ? ctrl_q[k] : 32'h0000_0000);
    end
    for (int k = 0; k < NUM_STAT; k++) begin
      rd_word_s = rd_word_s | ((rd_idx_s == IDXW'(STAT_BASE + k)) ? STAT_IN[32*k +: 32] : 32'h0000_0000);
    end
  end

  // Read FSM next state; data is registered at the AR handshake edge.
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs_s) begin
          rd_state_d = RD_RESP;
          rvalid_d   = 1'b1;
          rdata_d    = rd_word_s;
          rresp_d    = rd_mapped_s ? RESP_OKAY : RESP_SLVERR;
        end else begin
          rd_state_d = RD_IDLE;
        end
      end
      RD_RESP: begin
        if (r_hs_s) begin
          rd_state_d = RD_IDLE;
          rvalid_d   = 1'b0;
          rdata_d    = 32'h0000_0000;
          rresp_d    = RESP_OKAY;
        end else begin
          rd_state_d = RD_RESP;
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
      end
    endcase
    arready_d = (rd_state_q != RD_RESP) && (rd_state_d == RD_IDLE);
  end

  // Read FSM and read-channel registers.
  always_ff @(posedge AXI_S_ACLK or posedge AXI_S_ARESET) begin
    if (AXI_S_ARESET) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign AXI_S_AWREADY = awready_q;
  assign AXI_S_WREADY  = wready_q;
  assign AXI_S_BVALID  = bvalid_q;
  assign AXI_S_BRESP   = bresp_q;
  assign AXI_S_ARREADY = arready_q;
  assign AXI_S_RVALID  = rvalid_q;
  assign AXI_S_RDATA   = rdata_q;
  assign AXI_S_RRESP   = rresp_q;

  // Protection bits and byte offsets carry no meaning for this register file.
  assign unused_s = ^{AXI_S_AWPROT, AXI_S_ARPROT, AXI_S_ARADDR[1:0],
                      wr_addr_s[1:0], AXI_S_WSTRB, wstrb_q};

endmodule

// File: tb/tb_dft_axil_regs.sv
// -----------------------------------------------------------------------------
// tb_dft_axil_regs
// Randomised scoreboard bench for dft_axil_regs (default parameters).
// Stimulus tasks push expected B/R responses; a monitor pops and compares on
// every B/R handshake. The register model is a plain array/bit-mask model.
// -----------------------------------------------------------------------------
module tb_dft_axil_regs;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         AWVALID = 1'b0, AWREADY;
  logic [23:0]  AWADDR  = 24'h0;
  logic [2:0]   AWPROT  = 3'h0;
  logic         WVALID  = 1'b0, WREADY;
  logic [31:0]  WDATA   = 32'h0;
  logic [3:0]   WSTRB   = 4'h0;
  logic         BVALID, BREADY = 1'b0;
  logic [1:0]   BRESP;
  logic         ARVALID = 1'b0, ARREADY;
  logic [23:0]  ARADDR  = 24'h0;
  logic [2:0]   ARPROT  = 3'h0;
  logic         RVALID, RREADY = 1'b0;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic [127:0] CTRL_OUT;
  logic [127:0] STAT_IN = 128'h0;
  logic [0:0]   IRQ_SRC = 1'b0;
  logic         INTERRUPT;

  int n_checks = 0;
  int n_fail   = 0;
  bit hold_b   = 1'b0;

  // reference model
  logic [31:0] ctrl_m [4];
  logic [31:0] stat_v [4];
  logic [31:0] irq_stat_m = 32'h0;
  logic [31:0] irq_en_m   = 32'h0;
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];

  dft_axil_regs dut (
    .AXI_S_ACLK(clk), .AXI_S_ARESET(rst),
    .AXI_S_AWVALID(AWVALID), .AXI_S_AWREADY(AWREADY), .AXI_S_AWADDR(AWADDR), .AXI_S_AWPROT(AWPROT),
    .AXI_S_WVALID(WVALID), .AXI_S_WREADY(WREADY), .AXI_S_WDATA(WDATA), .AXI_S_WSTRB(WSTRB),
    .AXI_S_BVALID(BVALID), .AXI_S_BREADY(BREADY), .AXI_S_BRESP(BRESP),
    .AXI_S_ARVALID(ARVALID), .AXI_S_ARREADY(ARREADY), .AXI_S_ARADDR(ARADDR), .AXI_S_ARPROT(ARPROT),
    .AXI_S_RVALID(RVALID), .AXI_S_RREADY(RREADY), .AXI_S_RDATA(RDATA), .AXI_S_RRESP(RRESP),
    .CTRL_OUT(CTRL_OUT), .STAT_IN(STAT_IN), .IRQ_SRC(IRQ_SRC), .INTERRUPT(INTERRUPT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] s);
    logic [31:0] m;
`ifdef DFT_AXIL_WSTRB_EN
    for (int b = 0; b < 4; b++) m[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
`else
    m = 32'hFFFF_FFFF;
`endif
    return m;
  endfunction

  function automatic logic [127:0] ctrl_vec();
    return {ctrl_m[3], ctrl_m[2], ctrl_m[1], ctrl_m[0]};
  endfunction

  function automatic logic [33:0] exp_read(input int idx);
    if (idx == 0) return {2'b00, 32'hDF70_0002};
    if (idx == 1) return {2'b00, irq_stat_m & 32'h1};
    if (idx == 2) return {2'b00, irq_en_m & 32'h1};
    if (idx >= 3 && idx <= 6) return {2'b00, ctrl_m[idx-3]};
    if (idx >= 7 && idx <= 10) return {2'b00, stat_v[idx-7]};
    return {2'b10, 32'h0};
  endfunction

  task automatic model_write(input logic [23:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx = int'(addr[23:2]);
    logic [31:0] m = bmask(strb);
    exp_b.push_back((idx <= 10) ? 2'b00 : 2'b10);
    if (idx == 1) irq_stat_m = irq_stat_m & ~(data & m);
    else if (idx == 2) irq_en_m = ((irq_en_m & ~m) | (data & m)) & 32'h1;
    else if (idx >= 3 && idx <= 6) ctrl_m[idx-3] = (ctrl_m[idx-3] & ~m) | (data & m);
  endtask

  task automatic handshake_wait(input string name, input bit is_aw);
    int n = 0;
    while (!(is_aw ? AWREADY : WREADY) && n < 60) begin @(negedge clk); n++; end
    chk(name, 64'(n < 60), 64'd1);
  endtask

  task automatic aw_chan(input logic [23:0] addr);
    @(negedge clk);
    AWVALID = 1'b1; AWADDR = addr; AWPROT = 3'($urandom_range(0, 7));
    handshake_wait("aw_handshake", 1'b1);
    @(posedge clk); #1 AWVALID = 1'b0;
  endtask

  task automatic w_chan(input logic [31:0] data, input logic [3:0] strb);
    @(negedge clk);
    WVALID = 1'b1; WDATA = data; WSTRB = strb;
    handshake_wait("w_handshake", 1'b0);
    @(posedge clk); #1 WVALID = 1'b0;
  endtask

  // lag > 0: W follows AW by lag cycles; lag < 0: AW follows W.
  task automatic do_write(input logic [23:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lag, input bit pulse);
    model_write(addr, data, strb);
    if (pulse) irq_stat_m = irq_stat_m | 32'h1;
    if (pulse) begin
      int n = 0;
      @(negedge clk);
      while (!(AWREADY && WREADY) && n < 60) begin @(negedge clk); n++; end
      chk("aw_w_ready", 64'(n < 60), 64'd1);
      AWVALID = 1'b1; AWADDR = addr; WVALID = 1'b1; WDATA = data; WSTRB = strb; IRQ_SRC = 1'b1;
      @(posedge clk); #1;
      AWVALID = 1'b0; WVALID = 1'b0; IRQ_SRC = 1'b0;
    end else if (lag == 0) begin
      fork
        aw_chan(addr);
        w_chan(data, strb);
      join
    end else if (lag > 0) begin
      aw_chan(addr);
      repeat (lag) @(negedge clk);
      w_chan(data, strb);
    end else begin
      w_chan(data, strb);
      repeat (-lag) @(negedge clk);
      aw_chan(addr);
    end
  endtask

  task automatic do_read(input logic [23:0] addr);
    int n = 0;
    exp_r.push_back(exp_read(int'(addr[23:2])));
    @(negedge clk);
    ARVALID = 1'b1; ARADDR = addr; ARPROT = 3'($urandom_range(0, 7));
    while (!ARREADY && n < 60) begin @(negedge clk); n++; end
    chk("ar_handshake", 64'(n < 60), 64'd1);
    @(posedge clk); #1 ARVALID = 1'b0;
  endtask

  task automatic pulse_irq();
    @(negedge clk); IRQ_SRC = 1'b1;
    @(negedge clk); IRQ_SRC = 1'b0;
    irq_stat_m = irq_stat_m | 32'h1;
  endtask

  // Ready drivers: random back-pressure, BREADY can be forced low.
  initial begin
    forever begin
      @(posedge clk); #1;
      BREADY = hold_b ? 1'b0 : ($urandom_range(0, 3) != 0);
      RREADY = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare each B/R handshake against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst && BVALID && BREADY) begin
      if (exp_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_unexpected: response %0h with empty queue", BRESP);
      end else begin
        chk("bresp", 64'(BRESP), 64'(exp_b.pop_front()));
      end
    end
    if (!rst && RVALID && RREADY) begin
      if (exp_r.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL r_unexpected: data %0h with empty queue", RDATA);
      end else begin
        chk("rresp_rdata", {30'h0, RRESP, RDATA}, {30'h0, exp_r.pop_front()});
      end
    end
  end

  initial begin
    logic [31:0] d;
    int          idx, sel, lag, n;
    for (int k = 0; k < 4; k++) begin ctrl_m[k] = 32'h0; stat_v[k] = 32'h0; end

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_awready", 64'(AWREADY), 64'd0);
    chk("rst_bvalid",  64'(BVALID),  64'd0);
    chk("rst_rvalid",  64'(RVALID),  64'd0);
    chk("rst_rdata",   64'(RDATA),   64'd0);
    chk("rst_ctrl",    64'(CTRL_OUT[63:0]), 64'd0);
    chk("rst_int",     64'(INTERRUPT), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready_after_rst", {61'h0, AWREADY, WREADY, ARREADY}, 64'h7);
    do_read(24'h000000);

    // AW three cycles before W, BVALID held under back-pressure
    hold_b = 1'b1;
    do_write(24'h00000C, 32'h1234_5678, 4'hF, 3, 1'b0);
    chk("ctrl0_write", 64'(CTRL_OUT[31:0]), 64'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bvalid_held", {62'h0, BVALID, BRESP == 2'b00}, 64'h3);
    end
    hold_b = 1'b0;

    // unmapped address
    do_write(24'h000100, 32'hA5A5_A5A5, 4'hF, 0, 1'b0);
    do_read(24'h000100);
    chk("unmapped_no_change", CTRL_OUT[63:0], ctrl_vec()[63:0]);

    // IRQ path
    do_write(24'h000008, 32'h1, 4'hF, 0, 1'b0);
    pulse_irq();
    chk("int_not_yet", 64'(INTERRUPT), 64'd0);
    @(negedge clk);
    chk("int_rise", 64'(INTERRUPT), 64'd1);
    do_read(24'h000004);
    do_write(24'h000004, 32'h1, 4'hF, 0, 1'b1);
    do_read(24'h000004);
    repeat (2) @(negedge clk);
    chk("int_set_wins", 64'(INTERRUPT), 64'd1);
    do_write(24'h000004, 32'h1, 4'hF, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("int_cleared", 64'(INTERRUPT), 64'd0);
    do_read(24'h000004);

    // strobes
    do_write(24'h00000C, 32'hFFFF_FFFF, 4'hF, -1, 1'b0);
    do_write(24'h00000C, 32'h0000_0000, 4'b0101, 0, 1'b0);
`ifdef DFT_AXIL_WSTRB_EN
    chk("strobe_merge", 64'(CTRL_OUT[31:0]), 64'hFF00_FF00);
`else
    chk("strobe_ignored", 64'(CTRL_OUT[31:0]), 64'h0);
`endif

    // randomised traffic
    for (int it = 0; it < 80; it++) begin
      for (int k = 0; k < 4; k++) stat_v[k] = $urandom;
      STAT_IN = {stat_v[3], stat_v[2], stat_v[1], stat_v[0]};
      sel = $urandom_range(0, 13);
      idx = (sel == 13) ? 64 : sel;
      if ($urandom_range(0, 1) == 1) begin
        d   = $urandom;
        lag = int'($urandom_range(0, 5)) - 2;
        do_write(24'(idx * 4 + int'($urandom_range(0, 3))), d, 4'($urandom_range(0, 15)), lag, 1'b0);
        chk("ctrl_out", CTRL_OUT[63:0], ctrl_vec()[63:0]);
        chk("ctrl_out_hi", CTRL_OUT[127:64], ctrl_vec()[127:64]);
      end else begin
        do_read(24'(idx * 4 + int'($urandom_range(0, 3))));
      end
      if ($urandom_range(0, 4) == 0) pulse_irq();
      repeat (2) @(negedge clk);
      chk("interrupt", 64'(INTERRUPT), 64'((irq_stat_m & irq_en_m & 32'h1) != 32'h0));
    end

    // asynchronous reset with a pending write response
    hold_b = 1'b1;
    do_write(24'h000010, 32'hCAFE_F00D, 4'hF, 0, 1'b0);
    @(negedge clk);
    chk("bvalid_pending", 64'(BVALID), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("bvalid_abort", 64'(BVALID), 64'd0);
    chk("ctrl_abort", CTRL_OUT[63:0], 64'd0);
    void'(exp_b.pop_front());
    for (int k = 0; k < 4; k++) ctrl_m[k] = 32'h0;
    irq_stat_m = 32'h0; irq_en_m = 32'h0;
    @(negedge clk); rst = 1'b0; hold_b = 1'b0;
    do_write(24'h000014, 32'h0BAD_BEEF, 4'hF, 1, 1'b0);
    chk("ctrl2_after_rst", 64'(CTRL_OUT[95:64]), 64'h0BAD_BEEF);
    do_read(24'h000014);

    // drain scoreboard
    n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 300) begin @(negedge clk); n++; end
    chk("drain_b", 64'(exp_b.size()), 64'd0);
    chk("drain_r", 64'(exp_r.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dft_axil_regs.md
Name: dft_axil_regs

Overview:
- Parametrised AXI4-Lite slave register file; successor to the fixed single-IRQ register front end of the DFT FPGA.
- Sits between the AXI GP slave port (driven by axi4_slave_slot in simulation) and the DFT core.
- Provides configurable counts of control registers, status registers and interrupt sources.
- Adds decoupled AW/W acceptance, SLVERR on unmapped addresses, and a W1C interrupt status/enable pair.

Parameters:
- ADDR_WIDTH, 24, AXI byte address width.
- NUM_CTRL, 4, number of 32-bit read/write control registers (1..16).
- NUM_STAT, 4, number of 32-bit read-only status registers (1..16).
- IRQ_WIDTH, 1, number of interrupt sources (1..32).
- BLOCK_ID, 32'hDF70_0002, constant returned at word 0.

Ports:
- AXI_S_ACLK  in  1  sole clock.
- AXI_S_ARESET  in  1  reset, asynchronous, active-high.
- AXI_S_AWVALID/AWREADY  in/out  1  write-address handshake.
- AXI_S_AWADDR  in  ADDR_WIDTH  write byte address.
- AXI_S_AWPROT  in  3  ignored.
- AXI_S_WVALID/WREADY  in/out  1  write-data handshake.
- AXI_S_WDATA  in  32  write data.
- AXI_S_WSTRB  in  4  byte strobes.
- AXI_S_BVALID/BREADY  out/in  1  write-response handshake.
- AXI_S_BRESP  out  2  00 OKAY, 10 SLVERR.
- AXI_S_ARVALID/ARREADY  in/out  1  read-address handshake.
- AXI_S_ARADDR  in  ADDR_WIDTH  read byte address.
- AXI_S_ARPROT  in  3  ignored.
- AXI_S_RVALID/RREADY  out/in  1  read-data handshake.
- AXI_S_RDATA  out  32  read data.
- AXI_S_RRESP  out  2  read response.
- CTRL_OUT  out  NUM_CTRL*32  control registers; reg k occupies bits [32k+31:32k].
- STAT_IN  in  NUM_STAT*32  status inputs, sampled at read.
- IRQ_SRC  in  IRQ_WIDTH  one-cycle event pulses.
- INTERRUPT  out  1  level interrupt = |(IRQ_STATUS & IRQ_ENABLE).

Behaviour:
- Address map (word index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored):
  - 0: ID, read-only.
  - 1: IRQ_STATUS, write-1-to-clear.
  - 2: IRQ_ENABLE, read/write.
  - 3 .. 3+NUM_CTRL-1: CTRL registers.
  - next NUM_STAT words: STAT registers, read-only.
  - Any other word is unmapped: reads return 0 with SLVERR; writes are discarded with SLVERR.
  - Writes to ID or STAT are discarded and return OKAY.
- Reset values: all READY=0, all VALID=0, BRESP/RRESP=00, RDATA=0, CTRL=0, IRQ_STATUS=0, IRQ_ENABLE=0, INTERRUPT=0.
  - AWREADY, WREADY and ARREADY rise in the first cycle after reset deasserts.
- Write FSM, states IDLE, HAVE_AW, HAVE_W, RESP:
  - AW and W are each accepted independently, in either order or in the same cycle.
  - Once a channel is captured, its READY drops until the write completes.
  - When both are held: the register updates at that clock edge, BVALID rises the next cycle, and the FSM enters RESP.
  - RESP holds BVALID/BRESP stable until BREADY; then both READYs re-assert the next cycle (IDLE).
  - Throughput is 1 write per 3 cycles with BREADY tied high.
- Read FSM, states IDLE, RESP:
  - ARREADY=1 in IDLE; the AR handshake registers RDATA/RRESP, so RVALID rises the next cycle (latency 1).
  - RESP holds RDATA/RRESP stable until RREADY; ARREADY=0 during RESP.
  - STAT values are captured at the AR handshake edge.
- Read and write FSMs are independent.
  - If a read handshake and a write commit to the same register occur in the same edge, the read returns the pre-write value.
- IRQ:
  - IRQ_STATUS[i] is set on IRQ_SRC[i]=1 and cleared by a write of 1 to bit i.
  - Set wins over a simultaneous clear.
  - Bits at or above IRQ_WIDTH read 0 and are not writable.
  - INTERRUPT is registered: it rises 1 cycle after the status/enable condition becomes true.
- Async reset mid-transaction: both FSMs abort to the reset state immediately; no response is issued for the aborted transaction.

Optional Feature:
- Macro: DFT_AXIL_WSTRB_EN.
- Defined: writes to IRQ_ENABLE and CTRL update only the bytes whose WSTRB bit is 1. A W1C write clears only bits in strobed bytes.
- Undefined: WSTRB is ignored and every write is full-word.

Decomposition:
- Package dft_axil_pkg holds:
  - localparams for word indices ID_IDX=0, IRQ_STAT_IDX=1, IRQ_EN_IDX=2, CTRL_BASE=3.
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Enum typedefs for the write and read FSM states.
  - Function strb_merge(old, new, strb).
- One sub-module, dft_axil_irq: holds the IRQ_STATUS/IRQ_ENABLE registers, the set/clear priority and the registered INTERRUPT output.

Test Plan:
- Reset: after reset release, read word 0 -> RDATA=32'hDF70_0002, RRESP=00; CTRL_OUT=0; INTERRUPT=0.
- AW accepted 3 cycles before W: write 32'h1234_5678 to 0x0C -> CTRL_OUT[31:0]=32'h1234_5678, BRESP=00, BVALID held while BREADY=0 for 5 cycles.
- Unmapped address: write and read 0x100 with NUM_CTRL=NUM_STAT=4 -> BRESP=10, RRESP=10, RDATA=0, no register changes.
- IRQ path: set ENABLE=1, pulse IRQ_SRC[0] -> STATUS=1 and INTERRUPT=1 one cycle later.
  - Then W1C 1 coinciding with another IRQ_SRC pulse -> STATUS stays 1.
  - A further W1C with no pulse -> INTERRUPT=0.
- Strobes (macro defined): CTRL0=32'hFFFF_FFFF, then write 32'h0 with WSTRB=4'b0101 -> CTRL0=32'hFF00_FF00. With the macro undefined -> 32'h0.
- Reset asserted with a pending BVALID -> BVALID=0 immediately; the next write completes normally.
